// File: rtl/instr_encode_loader.sv
// Instruction encode loader: takes decoded RV32I fields over valid/ready,
// assembles the 32-bit word and writes it to consecutive imem word addresses.
module instr_encode_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [2:0]  fmt,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] count,
  output logic        err,
  output logic        full
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_ENCODE,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [2:0]  FMT_R = 3'd0;
  localparam logic [2:0]  FMT_I = 3'd1;
  localparam logic [2:0]  FMT_S = 3'd2;
  localparam logic [2:0]  FMT_B = 3'd3;
  localparam logic [2:0]  FMT_U = 3'd4;
  localparam logic [2:0]  FMT_J = 3'd5;
  localparam logic [6:0]  OP_IMM = 7'b0010011;
  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [2:0]  fmt_q, fmt_d;
  logic [6:0]  op_q, op_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        funct7b5_q, funct7b5_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [31:0] imm_q, imm_d;
  logic        last_q, last_d;
  logic        ok_q, ok_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;
  logic        full_q, full_d;

  logic        is_shift;
  logic        fits12;
  logic        fits13;
  logic        fits21;
  logic        enc_legal;
  logic [31:0] enc_word;
  logic [15:0] count_inc;
  logic        hit_max;

  // Sign-fit tests: every bit above the field's sign bit must equal it.
  assign fits12   = (&imm_q[31:11]) | ~(|imm_q[31:11]);
  assign fits13   = (&imm_q[31:12]) | ~(|imm_q[31:12]);
  assign fits21   = (&imm_q[31:20]) | ~(|imm_q[31:20]);
  assign is_shift = (fmt_q == FMT_I) && (op_q == OP_IMM) &&
                    ((funct3_q == 3'b001) || (funct3_q == 3'b101));

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b0;
    case (fmt_q)
      FMT_R: begin
        enc_word  = {1'b0, funct7b5_q, 5'b00000, rs2_q, rs1_q, funct3_q, rd_q, op_q};
        enc_legal = 1'b1;
      end
      FMT_I: begin
        if (is_shift) begin
          enc_word  = {1'b0, funct7b5_q, 5'b00000, imm_q[4:0], rs1_q, funct3_q, rd_q, op_q};
          enc_legal = ~(|imm_q[31:5]);
        end else begin
          enc_word  = {imm_q[11:0], rs1_q, funct3_q, rd_q, op_q};
          enc_legal = fits12;
        end
      end
      FMT_S: begin
        enc_word  = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], op_q};
        enc_legal = fits12;
      end
      FMT_B: begin
        enc_word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                     imm_q[4:1], imm_q[11], op_q};
        enc_legal = fits13 & ~imm_q[0];
      end
      FMT_U: begin
        enc_word  = {imm_q[31:12], rd_q, op_q};
        enc_legal = ~(|imm_q[11:0]);
      end
      FMT_J: begin
        enc_word  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
        enc_legal = fits21 & ~imm_q[0];
      end
      default: begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // Count after the current WRITE cycle; decides whether the region is full.
  assign count_inc = count_q + {15'd0, ok_q};
  assign hit_max   = (count_inc == MAX_CNT);

  always_comb begin
    state_d    = state_q;
    fmt_d      = fmt_q;
    op_d       = op_q;
    funct3_d   = funct3_q;
    funct7b5_d = funct7b5_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    imm_d      = imm_q;
    last_d     = last_q;
    ok_d       = ok_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    count_d    = count_q;
    err_d      = err_q;
    full_d     = full_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCEPT;
          addr_d  = BASE_ADDR;
          count_d = 16'd0;
          err_d   = 1'b0;
          full_d  = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          fmt_d      = fmt;
          op_d       = op;
          funct3_d   = funct3;
          funct7b5_d = funct7b5;
          rd_d       = rd;
          rs1_d      = rs1;
          rs2_d      = rs2;
          imm_d      = imm;
          last_d     = in_last;
          state_d    = S_ENCODE;
        end
      end
      S_ENCODE: begin
        ok_d    = enc_legal;
        if (enc_legal) begin
          wdata_d = enc_word;
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (ok_q) begin
          addr_d  = addr_q + 32'd4;
          count_d = count_inc;
        end else begin
          err_d = 1'b1;
        end
        if (hit_max) begin
          full_d = 1'b1;
        end
        if (last_q || hit_max) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ACCEPT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fmt_q      <= 3'd0;
      op_q       <= 7'd0;
      funct3_q   <= 3'd0;
      funct7b5_q <= 1'b0;
      rd_q       <= 5'd0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      imm_q      <= 32'd0;
      last_q     <= 1'b0;
      ok_q       <= 1'b0;
      wdata_q    <= 32'd0;
      addr_q     <= BASE_ADDR;
      count_q    <= 16'd0;
      err_q      <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fmt_q      <= fmt_d;
      op_q       <= op_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      imm_q      <= imm_d;
      last_q     <= last_d;
      ok_q       <= ok_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      full_q     <= full_d;
    end
  end

  // Strobe derives from state so a reset edge drops it immediately.
  assign in_ready   = (state_q == S_ACCEPT);
  assign imem_we    = (state_q == S_WRITE) && ok_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign count      = count_q;
  assign err        = err_q;
  assign full       = full_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized loads scored against an arithmetic encoding/loading model.
module tb_instr_encode_loader;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } bundle_t;

  typedef struct packed {
    bundle_t     b;
    logic        ok;
    logic [31:0] word;
  } vec_t;

  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic sel = 1'b0;
  logic [2:0]  fmt = '0;
  logic [6:0]  op = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;

  logic a_ready, a_we, a_busy, a_done, a_err, a_full;
  logic b_ready, b_we, b_busy, b_done, b_err, b_full;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [15:0] a_count, b_count;
  logic o_ready, o_we, o_busy, o_done, o_err, o_full;
  logic [31:0] o_addr, o_wdata;
  logic [15:0] o_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] wq[$];
  int wcyc[$];
  int hsq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_encode_loader #(.BASE_ADDR(BASE_A), .MAX_WORDS(256)) u_dut_a (
    .clk(clk), .reset(reset), .start(start & ~sel), .in_valid(in_valid & ~sel),
    .in_ready(a_ready), .in_last(in_last), .fmt(fmt), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata), .busy(a_busy),
    .done(a_done), .count(a_count), .err(a_err), .full(a_full)
  );

  instr_encode_loader #(.BASE_ADDR(BASE_B), .MAX_WORDS(2)) u_dut_b (
    .clk(clk), .reset(reset), .start(start & sel), .in_valid(in_valid & sel),
    .in_ready(b_ready), .in_last(in_last), .fmt(fmt), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata), .busy(b_busy),
    .done(b_done), .count(b_count), .err(b_err), .full(b_full)
  );

  assign o_ready = sel ? b_ready : a_ready;
  assign o_we    = sel ? b_we    : a_we;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_err   = sel ? b_err   : a_err;
  assign o_full  = sel ? b_full  : a_full;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_wdata = sel ? b_wdata : a_wdata;
  assign o_count = sel ? b_count : a_count;

  // Observe the selected loader away from the active edge.
  always @(negedge clk) begin
    if (o_we) begin
      wq.push_back({o_addr, o_wdata});
      wcyc.push_back(cyc);
    end
    if (o_ready && in_valid) hsq.push_back(cyc);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bundle_t mk(input logic [2:0] f, input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [31:0] i);
    bundle_t b;
    b.fmt = f; b.op = o; b.f3 = f3; b.f7 = f7; b.rd = d; b.rs1 = s1; b.rs2 = s2; b.imm = i;
    return b;
  endfunction

  // Reference encoding from the field-placement and range rules, using integer arithmetic.
  function automatic void ref_encode(input bundle_t b, output logic ok, output logic [31:0] w);
    logic [31:0] u;
    int s;
    logic [31:0] base;
    u = b.imm;
    s = $signed(b.imm);
    base = (32'(b.f3) << 12) | 32'(b.op);
    ok = 1'b0;
    w = 32'h0;
    case (b.fmt)
      3'd0: begin
        ok = 1'b1;
        w = (b.f7 ? 32'h4000_0000 : 32'h0) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
            | (32'(b.rd) << 7) | base;
      end
      3'd1: begin
        if (b.op == 7'h13 && (b.f3 == 3'd1 || b.f3 == 3'd5)) begin
          ok = (u < 32);
          w = (b.f7 ? 32'h4000_0000 : 32'h0) | ((u % 32) << 20) | (32'(b.rs1) << 15)
              | (32'(b.rd) << 7) | base;
        end else begin
          ok = (s >= -2048) && (s <= 2047);
          w = ((u % 4096) << 20) | (32'(b.rs1) << 15) | (32'(b.rd) << 7) | base;
        end
      end
      3'd2: begin
        ok = (s >= -2048) && (s <= 2047);
        w = (((u / 32) % 128) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
            | ((u % 32) << 7) | base;
      end
      3'd3: begin
        ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
        w = (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25) | (32'(b.rs2) << 20)
            | (32'(b.rs1) << 15) | (((u / 2) % 16) << 8) | (((u / 2048) % 2) << 7) | base;
      end
      3'd4: begin
        ok = (u % 4096 == 0);
        w = (u - (u % 4096)) | (32'(b.rd) << 7) | 32'(b.op);
      end
      3'd5: begin
        ok = (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
        w = (((u / 1048576) % 2) << 31) | (((u / 2) % 1024) << 21) | (((u / 2048) % 2) << 20)
            | (((u / 4096) % 256) << 12) | (32'(b.rd) << 7) | 32'(b.op);
      end
      default: ok = 1'b0;
    endcase
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    int s;
    b.fmt = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    b.op  = 7'($urandom);
    b.f3  = 3'($urandom);
    if (b.fmt == 3'd1 && $urandom_range(0, 1) == 1) begin
      b.op = 7'h13;
      b.f3 = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
    end
    b.f7  = 1'($urandom);
    b.rd  = 5'($urandom);
    b.rs1 = 5'($urandom);
    b.rs2 = 5'($urandom);
    case ($urandom_range(0, 3))
      0: begin s = int'($urandom_range(0, 10000)) - 5000; b.imm = 32'(s); end
      1: b.imm = $urandom;
      2: b.imm = $urandom & 32'hFFFF_F000;
      default: b.imm = 32'($urandom_range(0, 40));
    endcase
    return b;
  endfunction

  task automatic apply(input bundle_t b, input logic last);
    fmt = b.fmt; op = b.op; funct3 = b.f3; funct7b5 = b.f7;
    rd = b.rd; rs1 = b.rs1; rs2 = b.rs2; imm = b.imm; in_last = last;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns at posedge+1 of the handshake edge (loader then in its encode cycle).
  task automatic send(input bundle_t b, input logic last, input string name);
    logic got;
    got = 1'b0;
    apply(b, last);
    in_valid = 1'b1;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (o_ready) begin
        @(posedge clk); #1;
        got = 1'b1;
      end
    end
    in_valid = 1'b0;
    chk({name, "_accepted"}, 32'(got), 32'd1);
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(o_done), 32'd0);
    chk({name, "_busy_idle"}, 32'(o_busy), 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[12];

  initial begin
    logic ok;
    logic [31:0] w;
    bundle_t bl[$];
    logic [63:0] expq[$];
    int ecount;
    logic eerr;

    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    logic [31:0] w;
    bundle_t bb;
    bundle_t bl[$];
    logic [63:0] expq[$];
    int ecount;
    int n;
    logic eerr;
    string nm;

    vecs[0]  = '{b: mk(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5),          ok: 1'b1, word: 32'h0050_0093};
    vecs[1]  = '{b: mk(3'd5, 7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8),          ok: 1'b1, word: 32'h0080_00EF};
    vecs[2]  = '{b: mk(3'd4, 7'h37, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000),  ok: 1'b1, word: 32'h1234_52B7};
    vecs[3]  = '{b: mk(3'd1, 7'h13, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3),          ok: 1'b1, word: 32'h4030_D093};
    vecs[4]  = '{b: mk(3'd0, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0),          ok: 1'b1, word: 32'h0020_81B3};
    vecs[5]  = '{b: mk(3'd2, 7'h23, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8),          ok: 1'b1, word: 32'h0020_A423};
    vecs[6]  = '{b: mk(3'd3, 7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC),  ok: 1'b1, word: 32'hFE20_8EE3};
    vecs[7]  = '{b: mk(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048),       ok: 1'b0, word: 32'h0};
    vecs[8]  = '{b: mk(3'd3, 7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3),          ok: 1'b0, word: 32'h0};
    vecs[9]  = '{b: mk(3'd6, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0),          ok: 1'b0, word: 32'h0};
    vecs[10] = '{b: mk(3'd1, 7'h13, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32),         ok: 1'b0, word: 32'h0};
    vecs[11] = '{b: mk(3'd1, 7'h13, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'hFFFF_F800),  ok: 1'b1, word: 32'h8000_0113};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_we", 32'(o_we), 32'd0);
    chk("rst_addr", o_addr, BASE_A);
    chk("rst_addr_b", b_addr, BASE_B);
    chk("rst_wdata", o_wdata, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_full", 32'(o_full), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed single-instruction loads
    for (int i = 0; i < 12; i++) begin
      nm = $sformatf("vec%0d", i);
      pulse_start();
      wq.delete();
      send(vecs[i].b, 1'b1, nm);
      wait_done(nm);
      $display("vec %0d: fmt=%0d imm=%h writes=%0d err=%0d", i, vecs[i].b.fmt, vecs[i].b.imm, wq.size(), o_err);
      chk({nm, "_nwrites"}, 32'(wq.size()), vecs[i].ok ? 32'd1 : 32'd0);
      if (wq.size() == 1) begin
        chk({nm, "_word"}, wq[0][31:0], vecs[i].word);
        chk({nm, "_addr"}, wq[0][63:32], BASE_A);
      end
      chk({nm, "_err"}, 32'(o_err), 32'(!vecs[i].ok));
      chk({nm, "_count"}, 32'(o_count), 32'(vecs[i].ok));
    end

    // Four-instruction stream with latency check
    pulse_start();
    wq.delete(); wcyc.delete(); hsq.delete();
    send(vecs[4].b, 1'b0, "s0");
    send(mk(3'd0, 7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0), 1'b0, "s1");
    send(vecs[5].b, 1'b0, "s2");
    send(vecs[6].b, 1'b1, "s3");
    wait_done("stream");
    $display("stream: writes=%0d count=%0d", wq.size(), o_count);
    chk("stream_nwrites", 32'(wq.size()), 32'd4);
    chk("stream_count", 32'(o_count), 32'd4);
    chk("stream_err", 32'(o_err), 32'd0);
    if (wq.size() == 4 && hsq.size() == 4) begin
      chk("stream_w0", wq[0][31:0], 32'h0020_81B3);
      chk("stream_w1", wq[1][31:0], 32'h4020_81B3);
      chk("stream_w2", wq[2][31:0], 32'h0020_A423);
      chk("stream_w3", wq[3][31:0], 32'hFE20_8EE3);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("stream_addr%0d", i), wq[i][63:32], BASE_A + 32'(4 * i));
        chk($sformatf("stream_lat%0d", i), 32'(wcyc[i] - hsq[i]), 32'd2);
      end
    end

    // Errored bundles followed by a good one at the unadvanced address
    pulse_start();
    wq.delete();
    send(vecs[7].b, 1'b0, "e0");
    send(vecs[8].b, 1'b0, "e1");
    send(vecs[0].b, 1'b1, "e2");
    wait_done("errseq");
    $display("errseq: writes=%0d err=%0d count=%0d", wq.size(), o_err, o_count);
    chk("errseq_nwrites", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) begin
      chk("errseq_addr", wq[0][63:32], BASE_A);
      chk("errseq_word", wq[0][31:0], 32'h0050_0093);
    end
    chk("errseq_err", 32'(o_err), 32'd1);
    chk("errseq_count", 32'(o_count), 32'd1);

    // MAX_WORDS=2 instance with in_valid held high
    sel = 1'b1;
    pulse_start();
    wq.delete(); hsq.delete();
    apply(vecs[0].b, 1'b0);
    in_valid = 1'b1;
    wait_done("full");
    in_valid = 1'b0;
    $display("full: writes=%0d handshakes=%0d full=%0d", wq.size(), hsq.size(), o_full);
    chk("full_nwrites", 32'(wq.size()), 32'd2);
    chk("full_handshakes", 32'(hsq.size()), 32'd2);
    chk("full_flag", 32'(o_full), 32'd1);
    chk("full_count", 32'(o_count), 32'd2);
    chk("full_err", 32'(o_err), 32'd0);
    if (wq.size() == 2) begin
      chk("full_addr0", wq[0][63:32], BASE_B);
      chk("full_addr1", wq[1][63:32], BASE_B + 32'd4);
    end
    pulse_start();
    @(negedge clk);
    chk("restart_count", 32'(o_count), 32'd0);
    chk("restart_full", 32'(o_full), 32'd0);
    chk("restart_ready", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    wq.delete();
    send(vecs[3].b, 1'b1, "restart");
    wait_done("restart");
    chk("restart_nwrites", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) begin
      chk("restart_addr", wq[0][63:32], BASE_B);
      chk("restart_word", wq[0][31:0], 32'h4030_D093);
    end
    sel = 1'b0;
    @(posedge clk); #1;

    // Reset landing on the encode cycle
    pulse_start();
    wq.delete();
    send(vecs[0].b, 1'b1, "rstenc");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstenc_we", 32'(o_we), 32'd0);
    chk("rstenc_busy", 32'(o_busy), 32'd0);
    chk("rstenc_ready", 32'(o_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("rstenc_nowrite", 32'(wq.size()), 32'd0);
    $display("rstenc: writes after reset=%0d", wq.size());
    pulse_start();
    send(vecs[1].b, 1'b1, "rstenc_again");
    wait_done("rstenc_again");
    chk("rstenc_again_nwrites", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) begin
      chk("rstenc_again_addr", wq[0][63:32], BASE_A);
      chk("rstenc_again_word", wq[0][31:0], 32'h0080_00EF);
    end

    // Randomized loads against the reference model
    for (int l = 0; l < 30; l++) begin
      n = $urandom_range(1, 6);
      bl.delete(); expq.delete();
      ecount = 0; eerr = 1'b0;
      for (int i = 0; i < n; i++) begin
        bb = rand_bundle();
        bl.push_back(bb);
        ref_encode(bb, ok, w);
        if (ok) begin
          expq.push_back({BASE_A + 32'(4 * ecount), w});
          ecount++;
        end else begin
          eerr = 1'b1;
        end
      end
      pulse_start();
      wq.delete();
      for (int i = 0; i < n; i++) send(bl[i], (i == n - 1), $sformatf("rnd%0d_%0d", l, i));
      wait_done($sformatf("rnd%0d", l));
      $display("rnd %0d: bundles=%0d writes=%0d expected=%0d err=%0d", l, n, wq.size(), expq.size(), o_err);
      chk($sformatf("rnd%0d_nwrites", l), 32'(wq.size()), 32'(expq.size()));
      for (int i = 0; i < wq.size() && i < expq.size(); i++) begin
        chk($sformatf("rnd%0d_addr%0d", l, i), wq[i][63:32], expq[i][63:32]);
        chk($sformatf("rnd%0d_word%0d", l, i), wq[i][31:0], expq[i][31:0]);
      end
      chk($sformatf("rnd%0d_count", l), 32'(o_count), 32'(ecount));
      chk($sformatf("rnd%0d_err", l), 32'(o_err), 32'(eerr));
      chk($sformatf("rnd%0d_full", l), 32'(o_full), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Inverse of the RISC-V control/decode path: accepts decoded instruction fields over a valid/ready handshake and assembles legal RV32I instruction words.
- Writes each assembled word into instruction memory at consecutive word addresses.
- Used to load self-test programs into imem before the CPU is released, and by the bench to generate instruction streams for the single-cycle core.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written after start.
- MAX_WORDS, 256, number of words that fit in the program region; valid range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  in IDLE: begins a load at BASE_ADDR and clears count and flags; ignored in all other states.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  loader can accept a bundle.
- in_last  input  1  bundle is the final instruction of the program.
- fmt  input  3  encoding format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- op  input  7  opcode field, inserted verbatim.
- funct3  input  3  funct3 field (ignored for U and J).
- funct7b5  input  1  bit 30 for R-type and for I-type shifts.
- rd  input  5  destination register.
- rs1  input  5  first source register.
- rs2  input  5  second source register.
- imm  input  32  immediate as a signed byte value (U-type: the full 32-bit upper value).
- imem_we  output  1  one-cycle write strobe.
- imem_addr  output  32  byte address of the write.
- imem_wdata  output  32  assembled instruction.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the load ends.
- count  output  16  number of words written since start.
- err  output  1  sticky: an immediate was out of range or fmt was illegal.
- full  output  1  sticky: the load ended because MAX_WORDS was reached.

Behaviour:
- States: IDLE, ACCEPT, ENCODE, WRITE, DONE.
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, count=0, err=0, full=0.
- IDLE:
  - start=1 moves to ACCEPT and clears count, err and full.
  - imem_addr is loaded with BASE_ADDR.
- ACCEPT:
  - in_ready=1.
  - On in_valid&in_ready, all fields and in_last are registered and the state moves to ENCODE.
  - in_ready is 0 in every other state.
- ENCODE (one cycle): the word is formed from the registered fields.
  - R: {0,funct7b5,00000, rs2, rs1, funct3, rd, op}.
  - I: {imm[11:0], rs1, funct3, rd, op}. When op=0010011 and funct3 is 001 or 101, bits [31:25] become {0,funct7b5,00000} and imm[4:0] is the shift amount; imm[31:5] must be 0.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Range checks:
  - I and S: imm must sign-fit in 12 bits.
  - B: imm must sign-fit in 13 bits and imm[0]=0.
  - J: imm must sign-fit in 21 bits and imm[0]=0.
  - U: imm[11:0] must be 0.
  - fmt 6 or 7 is an error.
- WRITE:
  - Check passed: imem_we=1 for exactly this cycle, imem_wdata holds the word, imem_addr holds the current address. After the cycle, imem_addr advances by 4 and count advances by 1.
  - Check failed: no write, err is set, and address and count are unchanged.
- Leaving WRITE: goes to DONE if the registered in_last=1, or if count has reached MAX_WORDS (full is also set in the second case). Otherwise returns to ACCEPT.
- Latency: handshake accepted at edge N; imem_we is high in the cycle following edge N+1 (two cycles after acceptance). Peak throughput is one word per 3 cycles.
- DONE: done=1 for one cycle, then IDLE. busy falls in IDLE.
- count, err, full and imem_addr hold their values in IDLE until the next start.
- Errored bundles that carry in_last still end the load.
- Reset in any state returns to IDLE on that edge, and imem_we is 0 from that cycle on.
- start during busy has no effect.
- in_valid outside ACCEPT is ignored; the producer holds the bundle until accepted.
- Address arithmetic is 32-bit modulo 2^32.

Test Plan:
- Reset, then start. Send addi x1,x0,5 (fmt=1, op=0010011, f3=0, rd=1, imm=5) with in_last=1 → one write of 0x00500093 at 0x0, count=1, done pulses, err=0.
- Stream of four instructions:
  - add x3,x1,x2 → 0x002081B3 at 0x0.
  - sub x3,x1,x2 (funct7b5=1) → 0x402081B3 at 0x4.
  - sw x2,8(x1) → 0x0020A423 at 0x8.
  - beq x1,x2,-4 → 0xFE208EE3 at 0xC.
  - Expected: count=4 and each imem_we exactly two cycles after its handshake.
- jal x1,8 → 0x008000EF. lui x5 with imm=0x12345000 → 0x123452B7. srai x1,x1,3 (funct7b5=1) → 0x4030D093.
- Errors: addi with imm=2048 → no write, err=1. beq with imm=3 → no write, err=1. A following valid instruction is still written at the unadvanced address.
- MAX_WORDS=2 with in_valid held high → two writes, then full=1 and done, with no third handshake. Then a fresh start → count=0, full=0, writes resume at BASE_ADDR.
- Assert reset on the ENCODE cycle → no imem_we, busy=0 and in_ready=0 next cycle; a start pulse then restarts cleanly.
